alu_share_arb: RTL and testbench
================================

// Module: alu_share_arb
// PURPOSE
//  Shares one 8-bit two-stage ALU (alu: A,B,CTR in; registered result O) between two
//  requesters. Round-robin arbitration, one issue per cycle max. Tracks in-flight ops
//  through the ALU's fixed latency and returns each result tagged with its requester
//  id. Opcodes the ALU does not implement are caught here and never reach the ALU.
// PARAMETERS
//  W    8  operand/result width; must match the ALU
//  LAT  2  ALU latency: edges from operand capture to a valid result on alu_o
// PORTS
//  ck         in   1  clock, rising edge
//  rst_n      in   1  asynchronous reset, active low
//  req0/req1  in   1  request; held with op/a/b stable until the matching gnt
//  op0/op1    in   4  ALU opcode (CTR encoding)
//  a0/a1      in   W  operand A
//  b0/b1      in   W  operand B
//  gnt0/gnt1  out  1  combinational grant; the op is accepted at this rising edge
//  alu_a      out  W  to ALU A
//  alu_b      out  W  to ALU B
//  alu_ctr    out  4  to ALU CTR
//  alu_o      in   W  from ALU O
//  rsp_valid  out  1  registered; result valid this cycle
//  rsp_id     out  1  requester of the result (0/1)
//  rsp_err    out  1  op was illegal; rsp_data is 0
//  rsp_data   out  W  result
// BEHAVIOUR
//  Reset (async, rst_n=0): last_id=1, tag pipe cleared, and rsp_valid/rsp_id/rsp_err=0,
//   rsp_data=0. gnt0=gnt1=0 while rst_n=0.
//  Arbitration: only one req high -> grant it. Both high -> grant the id != last_id.
//   last_id <= granted id on each grant. At most one gnt per cycle. No starvation:
//   with both requesting, grants alternate 0,1,0,1...
//  Legal ops: 0000 add, 0001 sub, 1000 and, 1001 or, 1010 xor, 1011 not A, 1100 shr,
//   1101 shl, 1110 rotr, 1111 rotl. Results are mod 2^W with no carry or flag.
//  Illegal ops (0010-0111): granted normally, but alu_a/alu_b/alu_ctr are driven as
//   for idle. The op is tagged err and returns at normal latency with data 0.
//  ALU drive: on a legal grant, alu_a/alu_b/alu_ctr = the granted requester's a/b/op
//   (combinational mux). When idle or illegal: alu_a=0, alu_b=0, alu_ctr=0000.
//  Tag pipe: shift register of {valid,id,err}, LAT+1 stages, loaded on each grant.
//   - Granted in cycle n -> ALU captures at end of n -> alu_o valid in cycle n+LAT.
//   - Block registers alu_o (or 0 if err) at the end of cycle n+LAT.
//   - rsp_* is asserted in cycle n+LAT+1 for exactly one cycle. Total latency 3 for LAT=2.
//  Throughput: 1 op/cycle, fully pipelined, no backpressure. The consumer must accept
//   every rsp_valid cycle. Responses return in grant order.
//  No response without a grant. A cycle without a grant shifts an invalid bubble.
//  Requester dropping req before gnt: allowed, nothing issued. Request held after gnt:
//   treated as a new request next cycle.
//  Reset mid-operation: all in-flight tags are discarded. No rsp_valid follows the reset
//   for ops granted before it. The first grant after release goes to req0 if both request.
// TESTING
//  T1 add: req0 op=0000 a=12 b=34 granted cycle 5 -> cycle 8: rsp_valid=1 id=0 data=46.
//  T2 contention: req0 and req1 both high from reset release, req0 sub a=10 b=20,
//     req1 rotr a=81 -> gnt0 in cycle c, gnt1 in c+1.
//     Responses: c+3 id0 data F0; c+4 id1 data C0.
//  T3 illegal: req1 op=0011 a=FF b=01 -> gnt1=1, alu_ctr=0000 alu_a=00.
//     3 cycles later: rsp_err=1 id=1 data=00.
//  T4 streaming: req0 held high for 8 cycles with xor a=i b=55 (i=0..7) and req1 idle
//     -> 8 consecutive rsp_valid cycles, data=i^55 in order.
//  T5 fairness: both request for 10 cycles -> grants alternate. Exactly 5 grants each.
//  T6 reset: grant in cycle n, rst_n=0 in cycle n+1 for 1 cycle -> rsp_valid stays 0.
//     After release, the next op returns with normal latency.
//  All: random legal ops vs. a reference model. Check rsp_data, rsp_id and ordering.

Source files
------------

// File: rtl/alu_share_arb.sv
// Round-robin front end that shares one pipelined two-stage ALU between two requesters.
// Illegal opcodes are kept off the ALU. Each result returns tagged with the requester id.
module alu_share_arb #(
  parameter int W   = 8,
  parameter int LAT = 2
) (
  input  logic         ck,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [3:0]   op0,
  input  logic [3:0]   op1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_ctr,
  input  logic [W-1:0] alu_o,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic         rsp_err,
  output logic [W-1:0] rsp_data
);

  typedef struct packed {
    logic valid;
    logic id;
    logic err;
  } tag_t;

  logic         r_last_id;
  tag_t         r_tag [LAT];
  logic         w_gnt_any;
  logic         w_gnt_id;
  logic         w_legal;
  logic [3:0]   w_op;
  logic [W-1:0] w_a;
  logic [W-1:0] w_b;

  // With both requesting, the requester that was not served last wins.
  assign gnt0      = rst_n & req0 & (~req1 | r_last_id);
  assign gnt1      = rst_n & req1 & (~req0 | ~r_last_id);
  assign w_gnt_any = gnt0 | gnt1;
  assign w_gnt_id  = gnt1;

  assign w_op = w_gnt_id ? op1 : op0;
  assign w_a  = w_gnt_id ? a1  : a0;
  assign w_b  = w_gnt_id ? b1  : b0;

  // Implemented opcodes: 0000, 0001 and the whole 1xxx group.
  assign w_legal = w_op[3] | (w_op[2:1] == 2'b00);

  // NOTE: every output gets a default first so this block cannot infer a latch.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_ctr = 4'b0000;
    if (w_gnt_any && w_legal) begin
      alu_a   = w_a;
      alu_b   = w_b;
      alu_ctr = w_op;
    end
  end

  // NOTE: state uses non-blocking assignments so every stage shifts off the same edge.
  // NOTE: the tag pipe is reset on purpose, because discarding in-flight ops relies on it.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_last_id <= 1'b1;
      for (int i = 0; i < LAT; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      if (w_gnt_any) begin
        r_last_id <= w_gnt_id;
      end
      r_tag[0] <= '{valid: w_gnt_any,
                    id:    w_gnt_any & w_gnt_id,
                    err:   w_gnt_any & ~w_legal};
      for (int i = 1; i < LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // The last tag stage lines up with the ALU result, which is registered here one cycle later.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= r_tag[LAT-1].valid;
      rsp_id    <= r_tag[LAT-1].id;
      rsp_err   <= r_tag[LAT-1].err;
      rsp_data  <= (r_tag[LAT-1].valid && !r_tag[LAT-1].err) ? alu_o : '0;
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: behavioural two-stage ALU, a scoreboard model checked every cycle,
// directed cases with literal expectations, then randomized two-requester traffic.
module tb_alu_share_arb;

  logic       ck = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [3:0] op0, op1;
  logic [7:0] a0, a1, b0, b1;
  logic       gnt0, gnt1;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_ctr;
  logic [7:0] alu_o;
  logic       rsp_valid, rsp_id, rsp_err;
  logic [7:0] rsp_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  alu_share_arb #(.W(8), .LAT(2)) dut (
    .ck(ck), .rst_n(rst_n),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr), .alu_o(alu_o),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_data(rsp_data)
  );

  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  function automatic logic [7:0] ref_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b1000: return a & b;
      4'b1001: return a | b;
      4'b1010: return a ^ b;
      4'b1011: return ~a;
      4'b1100: return a >> 1;
      4'b1101: return a << 1;
      4'b1110: return {a[0], a[7:1]};
      4'b1111: return {a[6:0], a[7]};
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit is_legal(input logic [3:0] op);
    return !(op >= 4'd2 && op <= 4'd7);
  endfunction

  // Two-stage ALU: operands captured at one edge, result visible after the next.
  logic [7:0] alu_s1;
  always @(posedge ck) begin
    alu_s1 <= ref_op(alu_ctr, alu_a, alu_b);
    alu_o  <= alu_s1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard model: expected responses queued with the cycle they are due in.
  typedef struct {
    int         due;
    bit         id;
    bit         err;
    logic [7:0] data;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  bit         m_last = 1'b1;
  bit         m_any, m_id;
  logic [3:0] m_op;
  logic [7:0] m_a, m_b;
  bit         g_seen0 = 1'b0, g_seen1 = 1'b0;

  always @(negedge ck) begin
    g_seen0 = gnt0;
    g_seen1 = gnt1;
    if (!rst_n) begin
      check("rst_gnt0", 32'(gnt0), 32'(0));
      check("rst_gnt1", 32'(gnt1), 32'(0));
      check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      q.delete();
      m_last = 1'b1;
    end else begin
      m_any = req0 || req1;
      m_id  = (req0 && req1) ? !m_last : req1;
      check("m_gnt0", 32'(gnt0), 32'(m_any && !m_id));
      check("m_gnt1", 32'(gnt1), 32'(m_any && m_id));
      m_op = m_id ? op1 : op0;
      m_a  = m_id ? a1 : a0;
      m_b  = m_id ? b1 : b0;
      if (m_any && is_legal(m_op)) begin
        check("m_alu_ctr", 32'(alu_ctr), 32'(m_op));
        check("m_alu_a", 32'(alu_a), 32'(m_a));
        check("m_alu_b", 32'(alu_b), 32'(m_b));
      end else begin
        check("m_alu_idle", {12'h0, alu_ctr, alu_a, alu_b}, 32'(0));
      end
      if (m_any) begin
        e.due  = cyc + 3;
        e.id   = m_id;
        e.err  = !is_legal(m_op);
        e.data = e.err ? 8'h00 : ref_op(m_op, m_a, m_b);
        q.push_back(e);
        m_last = m_id;
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        check("m_rsp_valid", 32'(rsp_valid), 32'(1));
        check("m_rsp_id", 32'(rsp_id), 32'(e.id));
        check("m_rsp_err", 32'(rsp_err), 32'(e.err));
        check("m_rsp_data", 32'(rsp_data), 32'(e.data));
      end else begin
        check("m_rsp_idle", 32'(rsp_valid), 32'(0));
      end
    end
  end

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic mid();
    @(negedge ck);
  endtask

  task automatic drive(input int id, input bit r, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    if (id == 0) begin
      req0 = r; op0 = op; a0 = a; b0 = b;
    end else begin
      req1 = r; op1 = op; a1 = a; b1 = b;
    end
  endtask

  function automatic logic [3:0] rand_op();
    logic [3:0] tbl [10] = '{4'h0, 4'h1, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    if ($urandom_range(0, 9) == 0) return 4'($urandom_range(2, 7));
    return tbl[$urandom_range(0, 9)];
  endfunction

  int  cnt0, cnt1;
  bit  prev_g1;
  bit  held;

  initial begin
    // Reset with both already requesting (T2 stimulus held through reset).
    rst_n = 1'b0;
    drive(0, 1, 4'h1, 8'h10, 8'h20);
    drive(1, 1, 4'hE, 8'h81, 8'h00);
    mid();
    check("reset_rsp_data", 32'(rsp_data), 32'(0));
    check("reset_gnt", 32'({gnt0, gnt1}), 32'(0));

    // T2: contention from reset release; req0 first, then req1.
    step(); rst_n = 1'b1;
    mid(); check("t2_gnt0_first", 32'({gnt0, gnt1}), 32'(2'b10));
    step(); req0 = 1'b0;
    mid(); check("t2_gnt1_second", 32'({gnt0, gnt1}), 32'(2'b01));
    step(); req1 = 1'b0;
    mid(); check("t2_no_early_rsp", 32'(rsp_valid), 32'(0));
    step(); mid();
    check("t2_rsp0", 32'({rsp_valid, rsp_id, rsp_err, rsp_data}), 32'({3'b100, 8'hF0}));
    step(); mid();
    check("t2_rsp1", 32'({rsp_valid, rsp_id, rsp_err, rsp_data}), 32'({3'b110, 8'hC0}));

    // T1: single add, latency exactly 3.
    step(); drive(0, 1, 4'h0, 8'h12, 8'h34);
    mid(); check("t1_gnt0", 32'(gnt0), 32'(1));
    step(); req0 = 1'b0;
    mid();
    step(); mid(); check("t1_not_yet", 32'(rsp_valid), 32'(0));
    step(); mid();
    check("t1_rsp", 32'({rsp_valid, rsp_id, rsp_err, rsp_data}), 32'({3'b100, 8'h46}));
    step(); mid(); check("t1_one_cycle", 32'(rsp_valid), 32'(0));

    // T3: illegal opcode is granted but never reaches the ALU.
    step(); drive(1, 1, 4'h3, 8'hFF, 8'h01);
    mid();
    check("t3_gnt1", 32'(gnt1), 32'(1));
    check("t3_alu_ctr", 32'(alu_ctr), 32'(0));
    check("t3_alu_a", 32'(alu_a), 32'(0));
    step(); req1 = 1'b0;
    mid();
    step(); mid();
    step(); mid();
    check("t3_rsp", 32'({rsp_valid, rsp_id, rsp_err, rsp_data}), 32'({3'b111, 8'h00}));

    // T4: streaming xor from req0, one result per cycle in order.
    for (int t = 0; t < 11; t++) begin
      step();
      if (t < 8) drive(0, 1, 4'hA, 8'(t), 8'h55);
      else       req0 = 1'b0;
      mid();
      if (t < 8) check("t4_gnt0", 32'(gnt0), 32'(1));
      if (t >= 3) check("t4_rsp", 32'({rsp_valid, rsp_data}), 32'({1'b1, 8'(t - 3) ^ 8'h55}));
    end

    // T5: both requesting for 10 cycles -> strict alternation, 5 grants each.
    cnt0 = 0; cnt1 = 0; prev_g1 = 1'b0;
    for (int t = 0; t < 10; t++) begin
      step();
      drive(0, 1, rand_op(), 8'($urandom), 8'($urandom));
      drive(1, 1, rand_op(), 8'($urandom), 8'($urandom));
      mid();
      check("t5_one_gnt", 32'(gnt0) + 32'(gnt1), 32'(1));
      if (t > 0) check("t5_alternate", 32'(gnt1), 32'(!prev_g1));
      prev_g1 = gnt1;
      cnt0 += int'(gnt0);
      cnt1 += int'(gnt1);
    end
    check("t5_cnt0", 32'(cnt0), 32'(5));
    check("t5_cnt1", 32'(cnt1), 32'(5));
    step(); req0 = 1'b0; req1 = 1'b0;
    repeat (4) begin mid(); step(); end

    // T6: reset right after a grant discards it; next op has normal latency.
    drive(0, 1, 4'h0, 8'h01, 8'h02);
    mid(); check("t6_gnt0", 32'(gnt0), 32'(1));
    step(); rst_n = 1'b0; req0 = 1'b0;
    mid(); check("t6_in_reset", 32'(rsp_valid), 32'(0));
    step(); rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      mid(); check("t6_no_rsp", 32'(rsp_valid), 32'(0));
      step();
    end
    drive(0, 1, 4'h0, 8'h05, 8'h06);
    mid(); check("t6_gnt_after", 32'(gnt0), 32'(1));
    step(); req0 = 1'b0;
    mid(); step(); mid(); step(); mid();
    check("t6_rsp_after", 32'({rsp_valid, rsp_id, rsp_data}), 32'({2'b10, 8'h0B}));

    // Random traffic: hold until granted, occasional drop, mostly legal ops.
    for (int k = 0; k < 400; k++) begin
      step();
      for (int id = 0; id < 2; id++) begin
        held = (id == 0) ? (req0 && !g_seen0) : (req1 && !g_seen1);
        if (held) begin
          if ($urandom_range(0, 19) == 0) begin
            if (id == 0) req0 = 1'b0;
            else         req1 = 1'b0;
          end
        end else begin
          drive(id, $urandom_range(0, 99) < 60, rand_op(), 8'($urandom), 8'($urandom));
        end
      end
    end
    step(); req0 = 1'b0; req1 = 1'b0;
    repeat (6) step();
    mid();
    check("drain_empty", 32'(q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
